ste_xadc_drp_rd: RTL and testbench

- Sample-acquisition front end for the multimeter measurement path.
- On each XADC end-of-conversion it issues a DRP read of the selected channel status register and captures the conversion result.
- It then presents the result as a DATA_W-bit sample with a one-cycle strobe, which feeds the averaging stage's data input and update logic.
- It also flags DRP timeouts and counts conversions missed while a read is in flight.

---
 rtl/ste_xadc_drp_rd_pkg.sv | 25 ++
 rtl/ste_xadc_drp_rd_sat_cnt.sv | 23 ++
 rtl/ste_xadc_drp_rd.sv | 135 +++++++++++++
 tb/tb_ste_xadc_drp_rd.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ste_xadc_drp_rd_pkg.sv
// Shared types and constants for the XADC DRP sample-acquisition front end.
// Holds the FSM state type, the DRP status-register map and the result bit positions.
package ste_xadc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } drp_state_e;

    localparam logic [6:0] ADDR_TEMP   = 7'h00;
    localparam logic [6:0] ADDR_VCCINT = 7'h01;
    localparam logic [6:0] ADDR_VPVN   = 7'h03;
    localparam logic [6:0] ADDR_AUX0   = 7'h10;
    localparam logic [6:0] ADDR_AUX15  = 7'h1F;

    // XADC places its 12-bit conversion result left-justified in the 16-bit status word.
    localparam int XADC_RES_MSB = 15;
    localparam int XADC_RES_LSB = 4;

    function automatic logic [6:0] aux_addr(input logic [3:0] idx);
        return ADDR_AUX0 | {3'b000, idx};
    endfunction

endpackage

// File: rtl/ste_xadc_drp_rd_sat_cnt.sv
// Generic saturating up-counter with synchronous clear.
// Holds at all-ones once reached; clear takes priority over increment.
module ste_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/ste_xadc_drp_rd.sv
// XADC end-of-conversion to DRP read sequencer: issues one DRP read per accepted eoc,
// presents the result as a strobed sample, flags timeouts and counts dropped conversions.
//
// state | meaning
// IDLE  | waiting for an enabled eoc; address latched on acceptance
// REQ   | den asserted for this single cycle, timeout counter cleared
// WAIT  | waiting for drdy; captures on drdy, aborts when the counter hits its limit
module ste_xadc_drp_rd
    import ste_xadc_pkg::*;
#(
    parameter int         DATA_W      = 16,
    parameter int         TIMEOUT_CYC = 64,
    parameter logic [6:0] DEF_ADDR    = ADDR_VPVN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic [6:0]        ch_addr_i,
    input  logic              eoc_i,
    output logic              drp_den_o,
    output logic              drp_dwe_o,
    output logic [6:0]        drp_daddr_o,
    output logic [15:0]       drp_di_o,
    input  logic              drp_drdy_i,
    input  logic [15:0]       drp_do_i,
    output logic [DATA_W-1:0] sample_o,
    output logic              sample_valid_o,
    output logic              err_timeout_o,
    output logic [7:0]        overrun_cnt_o
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    drp_state_e state;
    drp_state_e state_nxt;
    logic [7:0] tmo_cnt;
    logic       accept;
    logic       capture;
    logic       timeout;
    logic       ovr_inc;
    logic       unused_do_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (eoc_i && enable_i) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (drp_drdy_i) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == REQ) begin
            tmo_cnt <= '0;
        end else if ((state == WAIT) && !capture && !timeout) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drp_daddr_o <= DEF_ADDR;
        end else if (accept) begin
            drp_daddr_o <= ch_addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            err_timeout_o  <= 1'b0;
        end else begin
            sample_valid_o <= capture;
            if (capture) begin
                sample_o      <= drp_do_i[XADC_RES_MSB -: DATA_W];
                err_timeout_o <= 1'b0;
            end else if (timeout) begin
                err_timeout_o <= 1'b1;
            end
        end
    end

    // Decoding den from the state register lets it drop the instant reset asserts.
    assign drp_den_o = (state == REQ);
    assign drp_dwe_o = 1'b0;
    assign drp_di_o  = 16'h0000;

    // Only enabled eoc seen while a read is in flight count as dropped conversions.
    assign ovr_inc = eoc_i && enable_i && (state != IDLE);

    ste_sat_cnt #(
        .W(8)
    ) u_ovr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ovr_inc),
        .clr   (1'b0),
        .cnt   (overrun_cnt_o)
    );

    assign unused_do_bits = ^drp_do_i;

endmodule

// File: tb/tb_ste_xadc_drp_rd.sv
// Self-checking bench: drives DRP read transactions into 16-bit and 12-bit instances and
// compares them against a transaction-level model of the acquisition behaviour.
module tb_ste_xadc_drp_rd;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        eoc = 1'b0;
    logic        drdy = 1'b0;
    logic [6:0]  ch_addr = '0;
    logic [15:0] drp_do = '0;

    logic        den16, dwe16, valid16, err16;
    logic [6:0]  daddr16;
    logic [15:0] di16, sample16;
    logic [7:0]  ovr16;
    logic        den12, dwe12, valid12, err12;
    logic [6:0]  daddr12;
    logic [15:0] di12;
    logic [11:0] sample12;
    logic [7:0]  ovr12;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int den_cnt = 0;
    int stb_cnt = 0;
    int last_stb = -100;
    int stb_gap = 0;

    logic [15:0] exp_s16 = '0;
    logic [11:0] exp_s12 = '0;
    logic        exp_err = 1'b0;
    int          exp_ovr = 0;

    always #5 clk = ~clk;

    ste_xadc_drp_rd #(.DATA_W(16), .TIMEOUT_CYC(T), .DEF_ADDR(7'h03)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .ch_addr_i(ch_addr), .eoc_i(eoc),
        .drp_den_o(den16), .drp_dwe_o(dwe16), .drp_daddr_o(daddr16), .drp_di_o(di16),
        .drp_drdy_i(drdy), .drp_do_i(drp_do), .sample_o(sample16),
        .sample_valid_o(valid16), .err_timeout_o(err16), .overrun_cnt_o(ovr16)
    );

    ste_xadc_drp_rd #(.DATA_W(12), .TIMEOUT_CYC(T), .DEF_ADDR(7'h03)) dut12 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .ch_addr_i(ch_addr), .eoc_i(eoc),
        .drp_den_o(den12), .drp_dwe_o(dwe12), .drp_daddr_o(daddr12), .drp_di_o(di12),
        .drp_drdy_i(drdy), .drp_do_i(drp_do), .sample_o(sample12),
        .sample_valid_o(valid12), .err_timeout_o(err12), .overrun_cnt_o(ovr12)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (den16) den_cnt++;
        if (valid16) begin
            stb_cnt++;
            check_val("strobe_spacing", 32'(cyc - last_stb >= 3), 32'd1);
            stb_gap  = cyc - last_stb;
            last_stb = cyc;
        end
    end

    task automatic check_outputs(input string tag);
        check_val({tag, "_sample16"}, 32'(sample16), 32'(exp_s16));
        check_val({tag, "_sample12"}, 32'(sample12), 32'(exp_s12));
        check_val({tag, "_err16"}, 32'(err16), 32'(exp_err));
        check_val({tag, "_err12"}, 32'(err12), 32'(exp_err));
        check_val({tag, "_ovr16"}, 32'(ovr16), 32'(exp_ovr));
        check_val({tag, "_ovr12"}, 32'(ovr12), 32'(exp_ovr));
    endtask

    // One read: eoc accepted, drdy k cycles after den (k > T means it arrives too late),
    // n_busy eoc pulses while the read is in flight with enable held at en_busy.
    task automatic do_read(input logic [6:0] addr, input int k, input logic [15:0] data,
                           input int n_busy, input logic en_busy);
        int  den0;
        int  stb0;
        int  m;
        logic good;
        den0 = den_cnt;
        stb0 = stb_cnt;
        m    = (k < T) ? k : T;
        good = (k <= T);
        step();
        eoc = 1'b1; enable = 1'b1; ch_addr = addr;
        step();
        eoc = 1'b0; ch_addr = 7'($urandom);
        check_val("den_pulse", 32'({den16, den12}), 32'h3);
        for (int j = 0; j <= k; j++) begin
            if (j <= m) check_val("daddr_stable", 32'({daddr12, daddr16}), 32'({addr, addr}));
            if (!good && j == T + 1) check_val("err_rise", 32'(err16), 32'd1);
            enable = en_busy;
            eoc    = (j < n_busy);
            drdy   = (j == k);
            drp_do = (j == k) ? data : 16'($urandom);
            step();
        end
        eoc = 1'b0; drdy = 1'b0; enable = 1'b1;
        if (good) begin
            exp_s16 = data;
            exp_s12 = data[15:4];
            exp_err = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        if (en_busy) exp_ovr = (exp_ovr + n_busy > 255) ? 255 : exp_ovr + n_busy;
        check_val("valid", 32'({valid16, valid12}), good ? 32'h3 : 32'h0);
        check_val("den_count", 32'(den_cnt - den0), 32'd1);
        check_val("strobe_count", 32'(stb_cnt - stb0), good ? 32'd1 : 32'd0);
        check_outputs("read");
    endtask

    initial begin
        int den0;
        int stb0;
        repeat (3) step();
        check_val("rst_den", 32'({den16, den12}), 32'h0);
        check_val("rst_daddr", 32'({daddr16, daddr12}), 32'({7'h03, 7'h03}));
        check_val("rst_const", 32'({dwe16, dwe12, di16 | di12}), 32'h0);
        check_val("rst_valid", 32'({valid16, valid12}), 32'h0);
        check_outputs("rst");
        rst_n = 1'b1;
        step();

        do_read(7'h03, 4, 16'hABC0, 0, 1'b1);
        do_read(7'h03, 2, 16'h7FF8, 0, 1'b1);
        do_read(7'h1A, T + 2, 16'hFFFF, 0, 1'b1);
        do_read(7'h00, 3, 16'h1230, 0, 1'b1);
        do_read(7'h11, T, 16'h8421, 0, 1'b1);
        do_read(7'h12, T + 1, 16'h0F0F, 0, 1'b1);
        do_read(7'h01, 5, 16'h5550, 3, 1'b1);
        do_read(7'h02, 4, 16'h3C3C, 3, 1'b0);
        do_read(7'h13, 1, 16'hC001, 2, 1'b1);

        den0 = den_cnt;
        enable = 1'b0; eoc = 1'b1;
        step();
        eoc = 1'b0;
        repeat (4) step();
        enable = 1'b1;
        check_val("gated_den", 32'(den_cnt - den0), 32'd0);
        check_outputs("gated");

        for (int i = 0; i < 20; i++) begin
            int k;
            int m;
            k = int'($urandom_range(T + 2, 1));
            m = (k < T) ? k : T;
            do_read(7'($urandom), k, 16'($urandom), int'($urandom_range(m + 1, 0)),
                    1'($urandom));
        end

        for (int i = 0; i < 34; i++) do_read(7'h10, T, 16'($urandom), T + 1, 1'b1);
        check_val("ovr_saturated", 32'(ovr16), 32'd255);
        do_read(7'h14, T + 1, 16'h1111, 0, 1'b1);

        step();
        eoc = 1'b1; enable = 1'b1; ch_addr = 7'h15;
        step();
        eoc = 1'b0;
        check_val("pre_rst_den", 32'(den16), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_async_den", 32'({den16, den12}), 32'h0);
        exp_s16 = '0; exp_s12 = '0; exp_err = 1'b0; exp_ovr = 0;
        step();
        step();
        rst_n = 1'b1;
        den0 = den_cnt;
        stb0 = stb_cnt;
        drdy = 1'b1; drp_do = 16'hBEEF;
        step();
        drdy = 1'b0;
        repeat (3) step();
        check_val("rst_mid_strobe", 32'(stb_cnt - stb0), 32'd0);
        check_val("rst_mid_den", 32'(den_cnt - den0), 32'd0);
        check_val("rst_mid_daddr", 32'(daddr16), 32'h03);
        check_outputs("rst_mid");

        for (int i = 0; i < 6; i++) begin
            do_read(7'h16, 1, 16'($urandom), 0, 1'b1);
            if (i > 0) check_val("b2b_gap", 32'(stb_gap), 32'd4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
